// File: rtl/if_id_fifo_pkg.sv
// -----------------------------------------------------------------------------
// if_id_fifo_pkg
// Shared constants for the IF/ID decoupling queue.
//   XLEN_DEFAULT / ILEN_DEFAULT : default pc and instruction widths.
//   Zero                        : bubble bit; replicate to any width for an
//                                 all-zero pc/instruction.
//   op_e                        : per-cycle queue operation, {push, pop}.
// -----------------------------------------------------------------------------
package if_id_fifo_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN_DEFAULT = 32;

  // Decode treats an all-zero instruction as a bubble.
  localparam logic Zero = 1'b0;

  // Bit order matches {push, pop}, so a plain cast classifies a cycle.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage : if_id_fifo_pkg

// File: rtl/if_id_fifo_if.sv
// -----------------------------------------------------------------------------
// if_id_fifo_if
// Handshake bundle between fetch (producer), the queue, and decode (consumer).
//   in_valid/in_pc/in_inst : fetched entry from IF
//   in_ready               : queue can accept (not full)
//   out_valid/out_pc/out_inst : head entry toward ID (zero when empty)
//   out_ready              : ID consumes the head (low = decode stall)
// Modports:
//   master : the pipeline side (drives IF entry and ID ready)
//   slave  : the queue itself
// -----------------------------------------------------------------------------
interface if_id_fifo_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);

  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [ILEN-1:0] in_inst;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_inst;
  logic            out_ready;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst
  );

endinterface : if_id_fifo_if

// File: rtl/if_id_fifo.sv
// -----------------------------------------------------------------------------
// if_id_fifo
// DEPTH-entry circular buffer of {pc, inst} between IF and ID, so fetch keeps
// running while decode stalls. A flush empties it in one cycle; when empty the
// head reads as an all-zero bubble.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset (same effect as flush)
//   flush : branch/jump redirect, discards every entry
//   bus   : if_id_fifo_if.slave handshake bundle
//   count : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module if_id_fifo
  import if_id_fifo_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int ILEN  = ILEN_DEFAULT,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  if_id_fifo_if.slave      bus,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               ENT_W    = XLEN + ILEN;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;
  op_e              w_op;

  // Ready looks only at occupancy: a full queue refuses a push even when the
  // head is being popped in the same cycle, keeping ready off the ID path.
  assign bus.in_ready  = (r_count != FULL_CNT);
  assign bus.out_valid = (r_count != '0);

  // A flush cancels both sides of the handshake for this cycle.
  assign w_push = bus.in_valid  && bus.in_ready  && !flush;
  assign w_pop  = bus.out_valid && bus.out_ready && !flush;
  assign w_op   = op_e'({w_push, w_pop});

  // Pointers wrap for free because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case (w_op)
        OP_PUSH: r_count <= r_count + CNT_W'(1);
        OP_POP:  r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because the head is gated to zero while count is zero.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.in_pc, bus.in_inst};
  end

  assign w_head = r_mem[r_rd_ptr];

  // NOTE: combinational outputs get a default first so no path can infer a
  // latch.
  always_comb begin
    bus.out_pc   = {XLEN{Zero}};
    bus.out_inst = {ILEN{Zero}};
    if (bus.out_valid) begin
      bus.out_pc   = w_head[ENT_W-1:ILEN];
      bus.out_inst = w_head[ILEN-1:0];
    end
  end

  assign count = r_count;

endmodule : if_id_fifo

// File: doc/if_id_fifo.md
# if_id_fifo

Parametrised fetch/decode decoupling queue between IF and ID. Replaces the single-entry IF/ID pipeline register with a DEPTH-entry circular buffer of {pc, inst} pairs under valid/ready handshakes, so fetch keeps running while decode stalls. A branch/jump flush empties it in one cycle. When empty, decode sees an all-zero bubble.

## Interface
- `XLEN`, 32: pc width.
- `ILEN`, 32: instruction width.
- `DEPTH`, 4: entries; power of two, ≥ 2.
- `CNT_W`, $clog2(DEPTH)+1: occupancy counter width (derived; do not override).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: jump/branch redirect; discards all entries.
- `in_valid` in 1: IF presents an entry.
- `in_pc` in XLEN: pc of fetched instruction.
- `in_inst` in ILEN: fetched instruction.
- `in_ready` out 1: queue can accept; equals !full.
- `out_valid` out 1: head entry valid; equals count != 0.
- `out_pc` out XLEN: head pc; `Zero` when empty.
- `out_inst` out ILEN: head instruction; `Zero` when empty.
- `out_ready` in 1: ID consumes head (low = decode stall).
- `count` out CNT_W: current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH×(XLEN+ILEN) array. `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Occupancy is held in a `count` register.
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready && !flush.
- push: write {in_pc, in_inst} at wr_ptr; wr_ptr+1.
- pop: rd_ptr+1.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Priority order: rst > flush > push/pop.
  - flush: wr_ptr = rd_ptr = count = 0 at next edge. A same-cycle push is dropped; a same-cycle pop does not count.
  - rst: identical to flush. Array contents are not reset (don't-care).
- in_ready depends only on count, never on out_ready. There is no combinational ready path, so a full queue rejects pushes even when a pop happens in the same cycle.
- out_pc/out_inst: combinational mux of array[rd_ptr] gated to `Zero` when count == 0. Downstream treats a zero instruction as a bubble, as today.
- in_valid while !in_ready: entry ignored. IF must hold it and retry.
- Pop while empty is impossible by construction (out_valid low).

## Timing
- Reset values:
  - count 0, out_valid 0, in_ready 1.
  - out_pc/out_inst `Zero`.
  - pointers 0.
- Latency is 1 cycle: an entry pushed at edge t is visible at the head after t if the queue was empty. This matches the old IF/ID register.
- Throughput: 1 push + 1 pop per cycle, sustained, when 0 < count < DEPTH.
- Empty, push and out_ready high in the same cycle: no pop. Entry appears next cycle with count = 1 (no bypass).
- Full (count = DEPTH): in_ready low. After a pop edge, in_ready rises in the following cycle.
- Flush: the cycle after flush shows out_valid 0, count 0, in_ready 1. A push is accepted in that cycle.
- Flush and rst asserted mid-stream behave identically. No partial state survives.

## Structure
- Shared package / config.v: `Zero`, and the XLEN/ILEN defaults.
- No sub-module needed. Storage is a plain register array inside the block.
- `fifo_ptr` is an optional helper (pointer + wrap). It is not required at this size.

## Test plan
- Reset, then idle: count 0, in_ready 1, out_valid 0, out_inst 0x00000000.
- Push pc 0x100/inst 0x00000013 into an empty queue with out_ready 0:
  - next cycle: out_valid 1, out_pc 0x100, count 1.
  - one cycle of out_ready: count 0, outputs zero.
- Hold out_ready 0 and push 5 entries (pc 0x0,0x4,…) with DEPTH=4:
  - in_ready drops after 4 pushes and the 5th is rejected.
  - draining yields pcs 0x0,0x4,0x8,0xC in order.
- Streaming 8 entries with in_valid and out_ready high every cycle:
  - pointers wrap past 3.
  - outputs appear in order, one cycle after push.
  - count steady at 1.
- Count 3, then flush with in_valid 1 and out_ready 1 in the same cycle:
  - next cycle count 0, out_valid 0.
  - the dropped pc never appears.
  - a push the following cycle appears normally.
- Queue full, then push and pop in the same cycle: the push is rejected (in_ready 0) and count goes to 3.
